// File: rtl/axi_rd_stream.sv
// AXI4 read master: splits linear reads into 4KB-safe AR bursts and streams R beats out through a FWFT FIFO.
// Bursts are issued only against reserved FIFO credit, so rready never drops and dout_ready alone throttles.

module axi_rd_stream_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          full;
   logic          do_rd;
   logic          do_wr;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_rd   = rd_en && !empty;
   // a read frees the slot, so a write alongside it is legal even when full
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rp];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wp] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_wr) wp <= wp + AW'(1);
         if (do_rd) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end
endmodule

module axi_rd_stream #(
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int LEN_W      = 20
) (
   input  logic             aclk,
   input  logic             arst,
   input  logic [39:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic [39:0]      araddr,
   output logic [7:0]       arlen,
   output logic             arvalid,
   input  logic             arready,
   input  logic [127:0]     rd_data,
   input  logic             rvalid,
   input  logic             rlast,
   output logic             rready,
   output logic [127:0]     dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_last,
   output logic             done,
   output logic             busy,
   output logic             err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_AREQ, S_DRAIN} state_t;

   state_t           state;
   logic [39:0]      addr;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] total;
   logic [LEN_W-1:0] delivered;
   logic [8:0]       len_r;
   logic [8:0]       len_c;
   logic [8:0]       bnd;
   logic [8:0]       cap;
   logic [CW-1:0]    credit;
   logic             ar_hs;
   logic             r_hs;
   logic             dout_hs;
   logic             df_empty;
   logic             lq_empty;
   logic             lq_rd;
   logic [7:0]       lq_head;
   logic [7:0]       bcnt;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^cmd_addr[3:0];

   assign ar_hs      = arvalid && arready;
   assign r_hs       = rvalid && rready;
   assign dout_valid = !df_empty;
   assign dout_hs    = dout_valid && dout_ready;
   assign dout_last  = dout_valid && ((delivered + LEN_W'(1)) == total);
   assign done       = (state == S_DRAIN) && (delivered == total);
   assign lq_rd      = r_hs && rlast && !lq_empty;

   // burst size: remaining beats, capped by MAX_BURST and by the beats left in this 4KB page
   always_comb begin
      bnd   = 9'd256 - {1'b0, addr[11:4]};
      cap   = (bnd < 9'(MAX_BURST)) ? bnd : 9'(MAX_BURST);
      len_c = (32'(rem) < 32'(cap)) ? 9'(rem) : cap;
   end

   always_ff @(posedge aclk) begin
      if (arst) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b0;
         arvalid   <= 1'b0;
         araddr    <= '0;
         arlen     <= '0;
         busy      <= 1'b0;
         addr      <= '0;
         rem       <= '0;
         total     <= '0;
         delivered <= '0;
         len_r     <= '0;
         credit    <= CW'(FIFO_DEPTH);
      end else begin
         credit <= credit + CW'(dout_hs) - (ar_hs ? CW'(len_r) : CW'(0));
         if (dout_hs) delivered <= delivered + LEN_W'(1);
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  addr      <= {cmd_addr[39:4], 4'h0};
                  rem       <= cmd_len;
                  total     <= cmd_len;
                  delivered <= '0;
                  busy      <= 1'b1;
                  state     <= (cmd_len == '0) ? S_DRAIN : S_CALC;
               end
            end
            S_CALC: begin
               // the credit seen here ignores this cycle's dout return, which only errs on the safe side
               if (32'(credit) >= 32'(len_c)) begin
                  arvalid <= 1'b1;
                  araddr  <= addr;
                  arlen   <= 8'(len_c - 9'd1);
                  len_r   <= len_c;
                  state   <= S_AREQ;
               end
            end
            S_AREQ: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  addr    <= addr + {27'd0, len_r, 4'h0};
                  rem     <= rem - LEN_W'(len_r);
                  state   <= (rem == LEN_W'(len_r)) ? S_DRAIN : S_CALC;
               end
            end
            S_DRAIN: begin
               if (delivered == total) begin
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (arst) rready <= 1'b0;
      else      rready <= 1'b1;
   end

   // rlast must coincide with the last beat of the oldest outstanding burst
   always_ff @(posedge aclk) begin
      if (arst) begin
         err  <= 1'b0;
         bcnt <= '0;
      end else if (r_hs) begin
         if (lq_empty) begin
            err <= 1'b1;
         end else begin
            if (rlast != (bcnt == lq_head)) err <= 1'b1;
            bcnt <= rlast ? 8'd0 : bcnt + 8'd1;
         end
      end
   end

   axi_rd_stream_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_lenq (
      .clk     (aclk),
      .rst     (arst),
      .wr_en   (ar_hs),
      .wr_data (arlen),
      .rd_en   (lq_rd),
      .rd_data (lq_head),
      .empty   (lq_empty)
   );

   axi_rd_stream_fifo #(.W(128), .DEPTH(FIFO_DEPTH)) u_data (
      .clk     (aclk),
      .rst     (arst),
      .wr_en   (r_hs),
      .wr_data (rd_data),
      .rd_en   (dout_hs),
      .rd_data (dout),
      .empty   (df_empty)
   );
endmodule

// File: tb/tb_axi_rd_stream.sv
// Bench for axi_rd_stream: randomized AXI slave, spec-level burst/beat model, scoreboard monitor.
module tb_axi_rd_stream;
   localparam int MAXB  = 16;
   localparam int DEPTH = 64;
   localparam int LEN_W = 20;

   typedef struct packed {logic [39:0] a; logic [7:0] l;} ar_t;
   typedef struct packed {logic [127:0] d; logic l;} beat_t;

   logic             aclk = 1'b0;
   logic             arst = 1'b1;
   logic [39:0]      cmd_addr = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [39:0]      araddr;
   logic [7:0]       arlen;
   logic             arvalid;
   logic             arready = 1'b0;
   logic [127:0]     rd_data = '0;
   logic             rvalid = 1'b0;
   logic             rlast = 1'b0;
   logic             rready;
   logic [127:0]     dout;
   logic             dout_valid;
   logic             dout_ready = 1'b0;
   logic             dout_last;
   logic             done;
   logic             busy;
   logic             err;

   int    checks = 0;
   int    errors = 0;
   ar_t   exp_ar[$];
   beat_t exp_beat[$];
   int    ar_total = 0;
   int    dout_total = 0;
   int    done_cnt = 0;
   int    occ = 0;
   int    dmode = 1;
   logic  fault = 1'b0;
   logic  err_exp = 1'b0;

   axi_rd_stream #(.MAX_BURST(MAXB), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .aclk(aclk), .arst(arst), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rd_data(rd_data), .rvalid(rvalid), .rlast(rlast), .rready(rready), .dout(dout),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last), .done(done),
      .busy(busy), .err(err)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // reference model: expected bursts and beats derived from the splitting rules
   task automatic issue_cmd(input logic [39:0] a_in, input int len);
      logic [39:0] a;
      int rem, n, b, to_pg, k;
      ar_t ea;
      beat_t eb;
      a = {a_in[39:4], 4'h0};
      rem = len;
      n = 0;
      while (rem > 0) begin
         to_pg = (4096 - int'(a % 40'd4096)) / 16;
         b = rem;
         if (b > MAXB) b = MAXB;
         if (b > to_pg) b = to_pg;
         ea.a = a;
         ea.l = 8'(b - 1);
         exp_ar.push_back(ea);
         for (int i = 0; i < b; i++) begin
            n++;
            eb.d = {80'h0, 8'(i), a};
            eb.l = (n == len);
            exp_beat.push_back(eb);
         end
         a = a + 40'(b * 16);
         rem -= b;
      end
      @(posedge aclk); #1;
      cmd_addr = a_in;
      cmd_len = LEN_W'(len);
      cmd_valid = 1'b1;
      k = 0;
      forever begin
         @(negedge aclk);
         if (cmd_ready || k >= 200) break;
         k++;
      end
      chk("cmd_accept", cmd_ready, 1'b1);
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int start, k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < 5000) begin
         @(negedge aclk);
         k++;
      end
      chk({nm, "_done_seen"}, done_cnt != start, 1'b1);
      @(negedge aclk);
      chk({nm, "_ar_left"}, exp_ar.size(), 0);
      chk({nm, "_beats_left"}, exp_beat.size(), 0);
   endtask

   // AXI slave: data = {beat index, burst start address}
   initial begin
      logic [39:0] bq_a[$];
      logic [7:0]  bq_l[$];
      int bi;
      logic ar_t_, r_t_, rs;
      logic [39:0] a;
      logic [7:0] l;
      bi = 0;
      forever begin
         @(negedge aclk);
         rs = arst;
         ar_t_ = arvalid && arready;
         a = araddr;
         l = arlen;
         r_t_ = rvalid && rready;
         @(posedge aclk); #1;
         if (rs) begin
            bq_a.delete();
            bq_l.delete();
            bi = 0;
            rvalid = 1'b0;
            rlast = 1'b0;
            arready = 1'b0;
         end else begin
            if (r_t_) begin
               bi++;
               if (bi > int'(bq_l[0])) begin
                  void'(bq_a.pop_front());
                  void'(bq_l.pop_front());
                  bi = 0;
               end
            end
            if (ar_t_) begin
               bq_a.push_back(a);
               bq_l.push_back(l);
            end
            if (bq_a.size() > 0 && $urandom_range(0, 3) != 0) begin
               rvalid = 1'b1;
               rd_data = {80'h0, 8'(bi), bq_a[0]};
               rlast = fault ? (bi == 2) : (bi == int'(bq_l[0]));
            end else begin
               rvalid = 1'b0;
               rlast = 1'b0;
            end
            arready = ($urandom_range(0, 2) != 0);
         end
      end
   end

   initial begin
      forever begin
         @(posedge aclk); #1;
         if (dmode == 0) dout_ready = 1'b0;
         else if (dmode == 1) dout_ready = 1'b1;
         else if (dmode == 2) dout_ready = 1'(($urandom_range(0, 1)));
      end
   end

   // monitor / scoreboard
   initial begin
      logic pend, stalled;
      logic [39:0] st_a;
      logic [7:0] st_l;
      int bchk, outst;
      beat_t eb;
      ar_t ea;
      pend = 1'b0; stalled = 1'b0; bchk = 0; outst = 0; st_a = '0; st_l = '0;
      forever begin
         @(negedge aclk);
         if (arst) begin
            pend = 1'b0; stalled = 1'b0; bchk = 0; outst = 0; occ = 0;
         end else begin
            if (done || pend) chk("done_timing", done, pend);
            if (done) begin
               done_cnt++;
               chk("err_at_done", err, err_exp);
            end
            if (bchk == 1) chk("busy_after_accept", busy, 1'b1);
            if (bchk == 2) chk("busy_after_done", busy, 1'b0);
            bchk = 0;
            if (cmd_valid && cmd_ready) bchk = 1;
            if (done) bchk = 2;
            pend = (cmd_valid && cmd_ready && cmd_len == '0) || (dout_valid && dout_ready && dout_last);
            if (rvalid && rready) begin
               occ++;
               outst--;
            end
            if (dout_valid && dout_ready) begin
               occ--;
               dout_total++;
               if (exp_beat.size() == 0) begin
                  chk("dout_unexpected", 1'b1, 1'b0);
               end else begin
                  eb = exp_beat.pop_front();
                  chk("dout_data", dout, eb.d);
                  chk("dout_last", dout_last, eb.l);
               end
            end
            if (rvalid && rready) chk("fifo_no_overflow", occ <= DEPTH, 1'b1);
            if (arvalid) begin
               if (stalled) chk("ar_stable", {araddr, arlen}, {st_a, st_l});
               if (arready) begin
                  stalled = 1'b0;
                  ar_total++;
                  outst += int'(arlen) + 1;
                  chk("credit_bound", (occ + outst) <= DEPTH, 1'b1);
                  if (exp_ar.size() == 0) begin
                     chk("ar_unexpected", 1'b1, 1'b0);
                  end else begin
                     ea = exp_ar.pop_front();
                     chk("ar_addr_len", {araddr, arlen}, {ea.a, ea.l});
                  end
               end else begin
                  stalled = 1'b1;
                  st_a = araddr;
                  st_l = arlen;
               end
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, k;
      logic [39:0] ra;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("reset_ctrl", {cmd_ready, arvalid, rready, dout_valid, dout_last, done, busy, err}, 8'h0);
      chk("reset_araddr", araddr, 40'h0);
      chk("reset_arlen", arlen, 8'h0);
      @(posedge aclk); #1;
      arst = 1'b0;
      repeat (3) @(negedge aclk);
      chk("idle_cmd_ready", cmd_ready, 1'b1);

      // burst split
      dmode = 1;
      base = dout_total;
      issue_cmd(40'h1000, 40);
      wait_done("split");
      chk("split_beats", dout_total - base, 40);

      // 4KB crossing, unaligned low nibble ignored
      base = dout_total;
      issue_cmd(40'h0FC7, 10);
      wait_done("cross4k");
      chk("cross4k_beats", dout_total - base, 10);

      // zero length
      base = ar_total;
      issue_cmd(40'h5000, 0);
      wait_done("zero");
      chk("zero_no_ar", ar_total - base, 0);

      // backpressure: credit gates AR issue
      dmode = 3;
      @(posedge aclk); #1;
      dout_ready = 1'b0;
      base = ar_total;
      issue_cmd(40'h0, 100);
      repeat (150) @(negedge aclk);
      chk("bp_ar_4", ar_total - base, 4);
      chk("bp_fifo_full", occ, DEPTH);
      chk("bp_dout_valid", dout_valid, 1'b1);
      @(posedge aclk); #1;
      dout_ready = 1'b1;
      repeat (15) @(posedge aclk);
      #1 dout_ready = 1'b0;
      repeat (40) @(negedge aclk);
      chk("bp_ar_still_4", ar_total - base, 4);
      @(posedge aclk); #1;
      dout_ready = 1'b1;
      @(posedge aclk); #1;
      dout_ready = 1'b0;
      repeat (40) @(negedge aclk);
      chk("bp_ar_5", ar_total - base, 5);
      dmode = 2;
      wait_done("bp");

      // randomized commands
      for (int c = 0; c < 10; c++) begin
         ra = {8'($urandom), 32'($urandom)};
         if (c % 2 == 0) ra[11:0] = 12'($urandom_range(3800, 4095));
         issue_cmd(ra, $urandom_range(0, 50));
         wait_done("rand");
      end

      // protocol error: early rlast
      dmode = 1;
      fault = 1'b1;
      err_exp = 1'b1;
      issue_cmd(40'h3000, 8);
      wait_done("fault");
      fault = 1'b0;
      chk("err_sticky_idle", err, 1'b1);
      issue_cmd(40'h3400, 20);
      wait_done("after_fault");

      // reset mid-command during second AR
      base = ar_total;
      issue_cmd(40'h1000, 40);
      k = 0;
      forever begin
         @(negedge aclk);
         if ((ar_total == base + 1 && arvalid) || k >= 2000) break;
         k++;
      end
      chk("rst_mid_reached", ar_total == base + 1, 1'b1);
      @(posedge aclk); #1;
      arst = 1'b1;
      @(posedge aclk); #1;
      arst = 1'b0;
      err_exp = 1'b0;
      exp_ar.delete();
      exp_beat.delete();
      @(negedge aclk);
      chk("rst_mid_ctrl", {cmd_ready, arvalid, rready, dout_valid, dout_last, done, busy, err}, 8'h0);
      chk("rst_mid_araddr", araddr, 40'h0);
      chk("rst_mid_arlen", arlen, 8'h0);
      base = dout_total;
      issue_cmd(40'h2000, 8);
      wait_done("post_reset");
      chk("post_reset_beats", dout_total - base, 8);
      chk("post_reset_err", err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
